led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer that drives the green LED bank with selectable animated patterns instead of a fixed blink. It contains a prescaler from CLOCK_50, a speed divider, a run/stop FSM with graceful stop, and pattern frame generators. It sits between the board switch/key decode logic and the LEDG pins.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz.
TICK_HZ, 4, base step rate in Hz; DIV = CLK_HZ/TICK_HZ, must be ≥2.
N_LEDS, 4, number of LEDs driven; range 2..8.

Ports:
CLOCK_50  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  level, sampled each cycle; begins or resumes animation.
stop  in  1  level, sampled each cycle; requests graceful stop.
mode  in  2  00 blink-all, 01 chase, 10 bounce, 11 binary count; latched on IDLE→RUN.
speed  in  2  step = base tick divided by 2^speed; sampled live.
LEDG  out  N_LEDS  LED drive, registered.
busy  out  1  high whenever state ≠ IDLE.
step_strobe  out  1  one-cycle pulse in the same cycle LEDG takes a new frame.

Behaviour:
- Reset (any time, including mid-animation): state=IDLE; LEDG=0; busy=0; step_strobe=0; prescaler, sub-counter, frame index, direction and latched mode all 0.
- Prescaler: cnt runs 0..DIV-1 and wraps. tick is high when cnt==DIV-1. cnt is held at 0 in IDLE.
- Speed divider: 3-bit sub counter sub increments on each tick and is held at 0 in IDLE. step = tick && ((sub & mask)==mask), where mask = 2^speed − 1. A speed change takes effect at the next tick.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: start=1 → RUN. Latch mode. LEDG ← frame 0 on the next edge (1-cycle latency). step_strobe pulses with it. Counters restart from 0. stop is ignored in IDLE. start and stop together in IDLE → start wins.
  - RUN: on each step, LEDG ← next frame and step_strobe=1. stop=1 → STOPPING. start is ignored. start and stop together → stop wins.
  - STOPPING: keep stepping. On the step whose next frame index is 0, go to IDLE with LEDG ← 0 (no strobe). start=1 without stop → back to RUN, frames continue, mode is not re-latched.
- Patterns (frame index k; bit 0 = LEDG[0]):
  - blink: k=0 all ones, k=1 all zeros; period 2.
  - chase: one-hot 1<<k; period N_LEDS.
  - bounce: one-hot moving up 0..N−1, then down N−2..1; period 2N−2. Direction flips at the ends. No end frame is repeated.
  - count: LEDG = k; period 2^N_LEDS.
- Frame index wraps to 0 after the last frame of the period.
- Width rules: frame index is ⌈log2(2^N_LEDS)⌉ = N_LEDS bits. All arithmetic is unsigned and wraps modulo its width.

Optional Feature:
Macro LED_PWM_DIM_EN.
- Defined: adds input bright[1:0] and a free-running 2-bit PWM counter p (runs even in IDLE, cleared by reset). Pin output = frame & {N_LEDS{p ≤ bright}}, giving duty (bright+1)/4. busy and step_strobe are unaffected.
- Not defined: no bright port; LEDG = frame register directly.

Decomposition:
- Package led_pkg: state enum (IDLE, RUN, STOPPING); mode encodings MODE_BLINK/MODE_CHASE/MODE_BOUNCE/MODE_COUNT; function calc_div(CLK_HZ, TICK_HZ).
- Sub-module led_tick_gen holds the prescaler plus speed divider.
  - Inputs: CLOCK_50, reset, enable, speed.
  - Output: step.
- The FSM and frame generation stay in led_pattern_ctrl.

Test Plan (CLK_HZ=8, TICK_HZ=2 → DIV=4, N_LEDS=4):
1. Reset mid-RUN (chase, LEDG=0100) → next edge LEDG=0000, busy=0; start afterwards restarts at 0001.
2. start pulse, mode=01, speed=0 → LEDG=0001 one cycle later with strobe, then 0010, 0100, 1000, 0001, each exactly 4 cycles apart.
3. mode=10, speed=1 → frames 0001,0010,0100,1000,0100,0010,0001, 8 cycles apart; changing mode mid-run has no effect.
4. mode=11 at frame 0101, assert stop → counting continues to 1111, then LEDG=0000, busy=0 on the step after 1111.
5. start and stop together in IDLE → RUN. In RUN, start and stop together → STOPPING. In STOPPING, start alone → RUN with no frame skip.
6. LED_PWM_DIM_EN, blink, bright=01 → during the all-on frame each LED is high 2 of every 4 cycles; bright=11 → constantly high.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Holds the FSM state enum, pattern mode encodings and the prescaler divide helper.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus speed divider producing the animation step pulse.
// Ports: CLOCK_50, reset, enable (counters held at 0 when low), speed[1:0], step.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  output logic       step
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    sub;
  logic [2:0]    mask;
  logic          tick;

  assign tick = enable && (cnt == LAST);
  // mask = 2^speed - 1, built without subtraction
  assign mask = ~(3'b111 << speed);
  assign step = tick && ((sub & mask) == mask);

  always_ff @(posedge CLOCK_50) begin
    if (reset || !enable) begin
      cnt <= '0;
      sub <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) sub <= sub + 3'd1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Animated pattern sequencer for the green LED bank (run/stop FSM + frame generation).
// Ports: CLOCK_50, reset, start, stop, mode[1:0], speed[1:0], [bright[1:0]], LEDG, busy, step_strobe.
// Optional macro LED_PWM_DIM_EN adds bright input and PWM dimming of LEDG.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 4,
  parameter int N_LEDS  = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
`ifdef LED_PWM_DIM_EN
  input  logic [1:0]        bright,
`endif
  output logic [N_LEDS-1:0] LEDG,
  output logic              busy,
  output logic              step_strobe
);

  localparam int N = N_LEDS;
  localparam logic [N-1:0] ONE = N'(1);

  state_t       state;
  logic [1:0]   mode_q;
  logic [N-1:0] idx;
  logic [N-1:0] nidx;
  logic [N-1:0] frame;
  logic         step;
  logic         resume;

  function automatic logic [N-1:0] last_of(input logic [1:0] md);
    last_of = '1;
    case (md)
      MODE_BLINK:  last_of = ONE;
      MODE_CHASE:  last_of = N'(N - 1);
      MODE_BOUNCE: last_of = N'(2 * N - 3);
      default:     last_of = '1;
    endcase
  endfunction

  function automatic logic [N-1:0] frame_of(input logic [1:0] md,
                                            input logic [N-1:0] k);
    frame_of = '0;
    case (md)
      MODE_BLINK:  frame_of = (k == '0) ? '1 : '0;
      MODE_CHASE:  frame_of = ONE << k;
      // upward leg is k itself, downward leg mirrors around N-1
      MODE_BOUNCE: frame_of = (k < N'(N)) ? (ONE << k)
                                          : (ONE << (N'(2 * N - 2) - k));
      default:     frame_of = k;
    endcase
  endfunction

  led_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .enable  (state != IDLE),
    .speed   (speed),
    .step    (step)
  );

  assign nidx   = (idx == last_of(mode_q)) ? '0 : idx + ONE;
  assign resume = (state == STOPPING) && start && !stop;
  assign busy   = (state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_BLINK;
      idx         <= '0;
      frame       <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            mode_q      <= mode;
            idx         <= '0;
            frame       <= frame_of(mode, '0);
            step_strobe <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          if (state == RUN && stop) state <= STOPPING;
          if (resume) state <= RUN;
          if (step) begin
            // a pending stop completes when the sequence wraps to frame 0
            if (state == STOPPING && !resume && nidx == '0) begin
              state <= IDLE;
              idx   <= '0;
              frame <= '0;
            end else begin
              idx         <= nidx;
              frame       <= frame_of(mode_q, nidx);
              step_strobe <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [1:0] p;

  always_ff @(posedge CLOCK_50) begin
    if (reset) p <= '0;
    else       p <= p + 2'd1;
  end

  assign LEDG = frame & {N{p <= bright}};
`else
  assign LEDG = frame;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl (CLK_HZ=8, TICK_HZ=2, N_LEDS=4).
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_led_pattern_ctrl;

  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 2;
  localparam int N       = 4;
  localparam int DIVC    = CLK_HZ / TICK_HZ;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [1:0]   speed = 2'd0;
`ifdef LED_PWM_DIM_EN
  logic [1:0]   bright = 2'd3;
`endif
  logic [N-1:0] LEDG;
  logic         busy;
  logic         step_strobe;

  int errors = 0;
  int checks = 0;

  int           m_state = 0;
  int           m_idx = 0;
  int           m_c = 0;
  logic [1:0]   m_mode = 2'd0;
  logic [1:0]   m_p = 2'd0;
  logic [N-1:0] m_frame = '0;
  logic         m_strobe = 1'b0;
  logic [N-1:0] exp_led;
  logic         exp_busy;
  logic         exp_strobe;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .N_LEDS (N)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .speed      (speed),
`ifdef LED_PWM_DIM_EN
    .bright     (bright),
`endif
    .LEDG       (LEDG),
    .busy       (busy),
    .step_strobe(step_strobe)
  );

  function automatic int period_of(input logic [1:0] md);
    case (md)
      2'd0:    return 2;
      2'd1:    return N;
      2'd2:    return 2 * N - 2;
      default: return 1 << N;
    endcase
  endfunction

  function automatic logic [N-1:0] frame_of(input logic [1:0] md, input int k);
    logic [N-1:0] seq[$];
    case (md)
      2'd0: return (k == 0) ? {N{1'b1}} : {N{1'b0}};
      2'd1: return N'(1) << k;
      2'd2: begin
        for (int i = 0; i < N; i++) seq.push_back(N'(1) << i);
        for (int i = N - 2; i >= 1; i--) seq.push_back(N'(1) << i);
        return seq[k];
      end
      default: return N'(k);
    endcase
  endfunction

  // Advance one clock and update the model from the inputs applied before the edge.
  task automatic step_cyc();
    int  t;
    int  ns;
    int  ni;
    bit  is_step;
    bit  res;
    if (reset) begin
      m_state = 0; m_idx = 0; m_c = 0; m_mode = 2'd0;
      m_p = 2'd0; m_frame = '0; m_strobe = 1'b0;
    end else begin
      m_p = m_p + 2'd1;
      m_strobe = 1'b0;
      if (m_state == 0) begin
        if (start) begin
          m_state = 1; m_mode = mode; m_idx = 0; m_c = 0;
          m_frame = frame_of(mode, 0); m_strobe = 1'b1;
        end
      end else begin
        t = m_c / DIVC + 1;
        is_step = (m_c % DIVC == DIVC - 1) && (t % (1 << speed) == 0);
        res = (m_state == 2) && start && !stop;
        if (m_state == 1) ns = stop ? 2 : 1;
        else              ns = res ? 1 : 2;
        m_c++;
        if (is_step) begin
          ni = (m_idx + 1) % period_of(m_mode);
          if (m_state == 2 && !res && ni == 0) begin
            ns = 0; m_idx = 0; m_frame = '0;
          end else begin
            m_idx = ni; m_frame = frame_of(m_mode, ni); m_strobe = 1'b1;
          end
        end
        m_state = ns;
      end
    end
    @(posedge clk);
    #1;
`ifdef LED_PWM_DIM_EN
    exp_led = (m_p <= bright) ? m_frame : '0;
`else
    exp_led = m_frame;
`endif
    exp_busy   = (m_state != 0);
    exp_strobe = m_strobe;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    step_cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (LEDG !== '0 || busy !== 1'b0 || step_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset: LEDG=%b busy=%b strobe=%b want 0000 0 0",
               LEDG, busy, step_strobe);
    end
  endtask

  task automatic test_chase();
    int last;
    logic [N-1:0] got[$];
    logic [N-1:0] want[5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mode = 2'd1; speed = 2'd0; start = 1'b1;
    step_cyc();
    start = 1'b0;
    last = 0;
    got.push_back(LEDG);
    checks++;
    if (LEDG !== 4'b0001 || step_strobe !== 1'b1) begin
      errors++;
      $display("FAIL chase_first: LEDG=%b strobe=%b want 0001 1", LEDG, step_strobe);
    end
    for (int i = 1; i <= 17; i++) begin
      step_cyc();
      checks++;
      if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL chase_model: LEDG=%b busy=%b strobe=%b want %b %b %b",
                 LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
      end
      if (step_strobe) begin
        got.push_back(LEDG);
        checks++;
        if (i - last != 4) begin
          errors++;
          $display("FAIL chase_gap: gap=%0d want 4", i - last);
        end
        last = i;
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== want[i]) begin
        errors++;
        $display("FAIL chase_seq[%0d]: got=%b want %b", i,
                 (i < got.size()) ? got[i] : 4'bxxxx, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit hit = 0;
    do_reset();
    mode = 2'd1; speed = 2'd0; start = 1'b1;
    step_cyc();
    start = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (LEDG === 4'b0100) hit = 1;
      else step_cyc();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_run_wait: LEDG=%b never reached 0100", LEDG);
    end
    reset = 1'b1;
    step_cyc();
    reset = 1'b0;
    checks++;
    if (LEDG !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset: LEDG=%b busy=%b want 0000 0", LEDG, busy);
    end
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    checks++;
    if (LEDG !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_restart: LEDG=%b busy=%b want 0001 1", LEDG, busy);
    end
  endtask

  task automatic test_bounce();
    int last = 0;
    logic [N-1:0] got[$];
    logic [N-1:0] want[7];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset();
    mode = 2'd2; speed = 2'd1; start = 1'b1;
    step_cyc();
    start = 1'b0;
    got.push_back(LEDG);
    for (int i = 1; i <= 50; i++) begin
      if (i == 20) mode = 2'd3;
      step_cyc();
      checks++;
      if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL bounce_model: LEDG=%b busy=%b strobe=%b want %b %b %b",
                 LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
      end
      if (step_strobe) begin
        got.push_back(LEDG);
        checks++;
        if (i - last != 8) begin
          errors++;
          $display("FAIL bounce_gap: gap=%0d want 8", i - last);
        end
        last = i;
      end
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== want[i]) begin
        errors++;
        $display("FAIL bounce_seq[%0d]: got=%b want %b", i,
                 (i < got.size()) ? got[i] : 4'bxxxx, want[i]);
      end
    end
    mode = 2'd0;
  endtask

  task automatic test_count_stop();
    bit hit = 0;
    logic [N-1:0] last_f = '0;
    do_reset();
    mode = 2'd3; speed = 2'd0; start = 1'b1;
    step_cyc();
    start = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (LEDG === 4'b0101) begin
        hit = 1;
      end else begin
        step_cyc();
        checks++;
        if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
          errors++;
          $display("FAIL count_model: LEDG=%b busy=%b strobe=%b want %b %b %b",
                   LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL count_wait: LEDG=%b never reached 0101", LEDG);
    end
    stop = 1'b1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step_cyc();
      checks++;
      if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL count_stop_model: LEDG=%b busy=%b strobe=%b want %b %b %b",
                 LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
      end
      if (step_strobe) last_f = LEDG;
      if (busy === 1'b0) hit = 1;
    end
    stop = 1'b0;
    checks++;
    if (!hit || last_f !== 4'b1111 || LEDG !== 4'b0000 || step_strobe !== 1'b0) begin
      errors++;
      $display("FAIL count_stop_end: idle=%0d last=%b LEDG=%b strobe=%b want 1 1111 0000 0",
               hit, last_f, LEDG, step_strobe);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    mode = 2'd1; speed = 2'd0; start = 1'b1; stop = 1'b1;
    step_cyc();
    checks++;
    if (busy !== 1'b1 || LEDG !== 4'b0001) begin
      errors++;
      $display("FAIL conflict_idle: busy=%b LEDG=%b want 1 0001", busy, LEDG);
    end
    for (int i = 0; i < 42; i++) begin
      if (i == 1) stop = 1'b0;
      if (i == 2) start = 1'b0;
      step_cyc();
      checks++;
      if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL conflict_model: LEDG=%b busy=%b strobe=%b want %b %b %b",
                 LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL conflict_resume: busy=%b want 1", busy);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      start = (r < 6) || (r >= 12 && r < 14);
      stop  = (r >= 6 && r < 14);
      reset = (r == 199);
      mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
`ifdef LED_PWM_DIM_EN
      bright = 2'($urandom_range(0, 3));
`endif
      step_cyc();
      checks++;
      if (LEDG !== exp_led || busy !== exp_busy || step_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL random[%0d]: LEDG=%b busy=%b strobe=%b want %b %b %b",
                 i, LEDG, busy, step_strobe, exp_led, exp_busy, exp_strobe);
      end
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef LED_PWM_DIM_EN
    bright = 2'd3;
`endif
  endtask

`ifdef LED_PWM_DIM_EN
  task automatic test_pwm();
    int on_cnt;
    bit uneven;
    do_reset();
    mode = 2'd0; speed = 2'd3; bright = 2'd1; start = 1'b1;
    step_cyc();
    start = 1'b0;
    on_cnt = 0;
    uneven = 0;
    for (int i = 0; i < 4; i++) begin
      step_cyc();
      if (LEDG === 4'b1111) on_cnt++;
      else if (LEDG !== 4'b0000) uneven = 1;
    end
    checks++;
    if (on_cnt != 2 || uneven) begin
      errors++;
      $display("FAIL pwm_half: on=%0d of 4 mixed=%0d want 2 0", on_cnt, uneven);
    end
    bright = 2'd3;
    on_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step_cyc();
      if (LEDG === 4'b1111) on_cnt++;
    end
    checks++;
    if (on_cnt != 4) begin
      errors++;
      $display("FAIL pwm_full: on=%0d of 4 want 4", on_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_chase();
    test_reset_mid_run();
    test_bounce();
    test_count_stop();
    test_conflict();
`ifdef LED_PWM_DIM_EN
    test_pwm();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
